// File: rtl/stage3_pkg.sv
// Shared definitions for the writeback stage: commit-mode codes, FSM states
// and small decode helpers used by the FSM.
package stage3_pkg;

    localparam int unsigned MODE_W         = 3;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned STORE16_BYTES  = 2;

    localparam logic [MODE_W-1:0] MB3_NOP     = 3'd0;
    localparam logic [MODE_W-1:0] MB3_STORE32 = 3'd1;
    localparam logic [MODE_W-1:0] MB3_STORE16 = 3'd2;
    localparam logic [MODE_W-1:0] MB3_JMP     = 3'd3;
    localparam logic [MODE_W-1:0] MB3_JZ      = 3'd4;
    localparam logic [MODE_W-1:0] MB3_JNZ     = 3'd5;

    typedef enum logic [1:0] {
        S3_IDLE  = 2'd0,
        S3_STORE = 2'd1,
        S3_DONE  = 2'd2
    } s3_state_e;

    // Reserved codes fall through to "not taken", i.e. behave as NOP.
    function automatic logic branch_taken(input logic [MODE_W-1:0] mode, input logic zero);
        logic taken;
        taken = 1'b0;
        case (mode)
            MB3_NOP: taken = 1'b0;
            MB3_JMP: taken = 1'b1;
            MB3_JZ:  taken = zero;
            MB3_JNZ: taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic is_store(input logic [MODE_W-1:0] mode);
        return (mode == MB3_STORE32) || (mode == MB3_STORE16);
    endfunction

endpackage

// File: rtl/stage3_writeback_if.sv
// STAGE2 -> writeback handshake plus the RAM write port and next-PC outputs.
interface stage3_writeback_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        mblock_s3;
    logic [DATA_W-1:0] vw_value;
    logic [ADDR_W-1:0] ram_address;
    logic              alu_is_zero;
    logic [ADDR_W-1:0] pc;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic              done;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_next;

    modport master (
        output in_valid, mblock_s3, vw_value, ram_address, alu_is_zero, pc,
        input  in_ready, ram_we, ram_waddr, ram_wdata, done, pc_load, pc_next
    );

    modport slave (
        input  in_valid, mblock_s3, vw_value, ram_address, alu_is_zero, pc,
        output in_ready, ram_we, ram_waddr, ram_wdata, done, pc_load, pc_next
    );
endinterface

// File: rtl/stage3_byte_serializer.sv
// Emits a latched word as consecutive little-endian byte writes, one per cycle,
// starting the cycle after the start pulse.
module stage3_byte_serializer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [DATA_W-1:0] word,
    input  logic [CNT_W-1:0]  nbytes,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              last_c
);
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;

    // cnt_q counts bytes still to present, including the one on the bus now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we      <= 1'b0;
            addr    <= '0;
            data    <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            we      <= 1'b1;
            addr    <= base;
            data    <= word[7:0];
            shift_q <= word >> 8;
            cnt_q   <= nbytes;
        end else if (we) begin
            if (cnt_q == CNT_W'(1)) begin
                we    <= 1'b0;
                cnt_q <= '0;
            end else begin
                addr    <= addr + ADDR_W'(1);
                data    <= shift_q[7:0];
                shift_q <= shift_q >> 8;
                cnt_q   <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign last_c = we && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/stage3_writeback.sv
// Final pipeline stage: commits a STAGE2 result as a byte-serial RAM store or
// as a next-PC update (branch or sequential).
module stage3_writeback
    import stage3_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8 * BYTES_PER_WORD,
    parameter int unsigned INSTR_BYTES = 4
) (
    input logic               clk,
    input logic               rst_n,
    stage3_writeback_if.slave bus
);
    localparam int unsigned WORD_BYTES = DATA_W / 8;
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES + 1);

    s3_state_e         state, next_state;
    logic [ADDR_W-1:0] pc_q;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic              start_c;
    logic              accept_c;
    logic [CNT_W-1:0]  len_c;
    logic              ser_we, ser_last_c;
    logic [ADDR_W-1:0] ser_addr;
    logic [7:0]        ser_data;

    assign accept_c = (state == S3_IDLE) && bus.in_valid;
    assign len_c    = (bus.mblock_s3 == MB3_STORE32) ? CNT_W'(WORD_BYTES) : CNT_W'(STORE16_BYTES);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S3_IDLE;
            pc_q       <= '0;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            pc_next_q  <= '0;
        end else begin
            state      <= next_state;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            pc_next_q  <= pc_next_d;
            if (accept_c) begin
                pc_q <= bus.pc;
            end
        end
    end

    // Next state; non-store modes resolve the branch from the live inputs at accept.
    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        done_d     = 1'b0;
        pc_next_d  = pc_next_q;
        case (state)
            S3_IDLE: begin
                if (bus.in_valid) begin
                    if (is_store(bus.mblock_s3)) begin
                        start_c    = 1'b1;
                        next_state = S3_STORE;
                    end else begin
                        next_state = S3_DONE;
                        done_d     = 1'b1;
                        pc_next_d  = branch_taken(bus.mblock_s3, bus.alu_is_zero)
                                   ? bus.vw_value[ADDR_W-1:0]
                                   : bus.pc + ADDR_W'(INSTR_BYTES);
                    end
                end
            end
            S3_STORE: begin
                if (ser_last_c) begin
                    next_state = S3_DONE;
                    done_d     = 1'b1;
                    pc_next_d  = pc_q + ADDR_W'(INSTR_BYTES);
                end
            end
            S3_DONE: next_state = S3_IDLE;
            default: next_state = S3_IDLE;
        endcase
        in_ready_d = (next_state == S3_IDLE);
    end

    stage3_byte_serializer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
        .base   (bus.ram_address),
        .word   (bus.vw_value),
        .nbytes (len_c),
        .we     (ser_we),
        .addr   (ser_addr),
        .data   (ser_data),
        .last_c (ser_last_c)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.ram_we    = ser_we;
    assign bus.ram_waddr = ser_addr;
    assign bus.ram_wdata = ser_data;
    assign bus.done      = done_q;
    assign bus.pc_load   = done_q;
    assign bus.pc_next   = pc_next_q;

endmodule

// File: tb/tb_stage3_writeback.sv
// Bench for stage3_writeback: a per-cycle timeline model of the expected
// outputs, checked every cycle, plus literal expectations per directed vector.
module tb_stage3_writeback;

    typedef struct {
        bit          in_ready;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          done;
        logic [15:0] pc_next;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit   started = 1'b0;
    int   vectors = 0;
    int   fails = 0;

    rec_t        sched[$];
    rec_t        cur;
    logic [15:0] pc_hold;
    logic [23:0] obs_w[$];
    logic [15:0] obs_pc[$];

    stage3_writeback_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    stage3_writeback #(.ADDR_W(16), .DATA_W(32), .INSTR_BYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic rec_t idle_rec();
        rec_t r;
        r.in_ready = 1'b1; r.we = 1'b0; r.addr = '0; r.data = '0;
        r.done = 1'b0; r.pc_next = '0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accept queues N write cycles then one done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched.delete();
            cur     = idle_rec();
            pc_hold = '0;
        end else begin
            if (cur.in_ready && bus.in_valid) begin
                int   n;
                bit   taken;
                rec_t r;
                n = (bus.mblock_s3 == 3'd1) ? 4 : (bus.mblock_s3 == 3'd2) ? 2 : 0;
                for (int k = 0; k < n; k++) begin
                    r = idle_rec();
                    r.in_ready = 1'b0;
                    r.we       = 1'b1;
                    r.addr     = bus.ram_address + 16'(k);
                    r.data     = 8'(bus.vw_value >> (8 * k));
                    sched.push_back(r);
                end
                taken = (bus.mblock_s3 == 3'd3) ||
                        (bus.mblock_s3 == 3'd4 && bus.alu_is_zero) ||
                        (bus.mblock_s3 == 3'd5 && !bus.alu_is_zero);
                r = idle_rec();
                r.in_ready = 1'b0;
                r.done     = 1'b1;
                r.pc_next  = taken ? bus.vw_value[15:0] : bus.pc + 16'd4;
                sched.push_back(r);
            end
            cur = (sched.size() != 0) ? sched.pop_front() : idle_rec();
            if (cur.done) pc_hold = cur.pc_next;
        end
    end

    always @(negedge clk) begin
        if (rst_n && started) begin
            chk("in_ready", 32'(bus.in_ready), 32'(cur.in_ready));
            chk("ram_we", 32'(bus.ram_we), 32'(cur.we));
            if (cur.we) begin
                chk("ram_waddr", 32'(bus.ram_waddr), 32'(cur.addr));
                chk("ram_wdata", 32'(bus.ram_wdata), 32'(cur.data));
            end
            chk("done", 32'(bus.done), 32'(cur.done));
            chk("pc_load", 32'(bus.pc_load), 32'(cur.done));
            chk("pc_next", 32'(bus.pc_next), 32'(pc_hold));
            if (bus.ram_we) obs_w.push_back({bus.ram_waddr, bus.ram_wdata});
            if (bus.done) obs_pc.push_back(bus.pc_next);
        end
    end

    task automatic send(input logic [2:0] m, input logic [31:0] v, input logic [15:0] a,
                        input logic z, input logic [15:0] p);
        int t;
        @(negedge clk);
        bus.mblock_s3 = m; bus.vw_value = v; bus.ram_address = a;
        bus.alu_is_zero = z; bus.pc = p; bus.in_valid = 1'b1;
        t = 0;
        while (!cur.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cur.in_ready && t < 50);
        if (t >= 50) chk("idle_timeout", 32'd1, 32'd0);
        #1;
    endtask

    task automatic clear_obs();
        obs_w.delete();
        obs_pc.delete();
    endtask

    logic [2:0]  br_mode[6] = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd3, 3'd3};
    logic        br_zero[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] br_exp [6] = '{16'h1234, 16'h0204, 16'h0204, 16'h1234, 16'h1234, 16'h1234};
    logic [2:0]  hold_mode[2] = '{3'd0, 3'd7};

    initial begin
        bus.in_valid = 1'b0; bus.mblock_s3 = '0; bus.vw_value = '0;
        bus.ram_address = '0; bus.alu_is_zero = 1'b0; bus.pc = '0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_waddr", 32'(bus.ram_waddr), 32'd0);
        chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
        chk("rst_pc_next", 32'(bus.pc_next), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        started = 1'b1;
        @(negedge clk);
        #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // STORE32, little-endian bytes at consecutive addresses
        clear_obs();
        send(3'd1, 32'h11223344, 16'h0010, 1'b0, 16'd84);
        wait_idle();
        chk("s32_nwrites", 32'(obs_w.size()), 32'd4);
        chk("s32_b0", 32'(obs_w[0]), 32'h001044);
        chk("s32_b1", 32'(obs_w[1]), 32'h001133);
        chk("s32_b2", 32'(obs_w[2]), 32'h001222);
        chk("s32_b3", 32'(obs_w[3]), 32'h001311);
        chk("s32_pc", 32'(obs_pc[0]), 32'd88);

        // STORE16 with address wrap
        clear_obs();
        send(3'd2, 32'h0000ABCD, 16'hFFFF, 1'b0, 16'h0100);
        wait_idle();
        chk("s16_nwrites", 32'(obs_w.size()), 32'd2);
        chk("s16_b0", 32'(obs_w[0]), 32'hFFFFCD);
        chk("s16_b1", 32'(obs_w[1]), 32'h0000AB);
        chk("s16_pc", 32'(obs_pc[0]), 32'h0104);

        // Branches: JZ, JNZ, JMP with both zero-flag values
        for (int i = 0; i < 6; i++) begin
            clear_obs();
            send(br_mode[i], 32'h00001234, 16'h0050, br_zero[i], 16'h0200);
            wait_idle();
            chk("br_nwrites", 32'(obs_w.size()), 32'd0);
            chk("br_ndone", 32'(obs_pc.size()), 32'd1);
            chk("br_pc", 32'(obs_pc[0]), 32'(br_exp[i]));
        end

        // in_valid held high: one commit every two cycles, NOP and reserved code
        for (int i = 0; i < 2; i++) begin
            clear_obs();
            @(negedge clk);
            bus.mblock_s3 = hold_mode[i]; bus.pc = 16'd84; bus.vw_value = 32'h0000BEEF;
            bus.in_valid = 1'b1;
            repeat (8) @(negedge clk);
            #1 bus.in_valid = 1'b0;
            chk("hold_ndone", 32'(obs_pc.size()), 32'd4);
            foreach (obs_pc[j]) chk("hold_pc", 32'(obs_pc[j]), 32'd88);
            chk("hold_nwrites", 32'(obs_w.size()), 32'd0);
            wait_idle();
        end

        // Async reset during byte 2 of a STORE32
        clear_obs();
        send(3'd1, 32'hCAFEF00D, 16'h0400, 1'b0, 16'h0010);
        @(negedge clk);
        @(negedge clk);
        #1 chk("abort_we_before", 32'(bus.ram_we), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("abort_we_async", 32'(bus.ram_we), 32'd0);
        chk("abort_nwrites", 32'(obs_w.size()), 32'd3);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_no_more", 32'(obs_w.size()), 32'd3);

        // Inputs changing after accept must not affect the store
        clear_obs();
        send(3'd1, 32'hA1B2C3D4, 16'h2000, 1'b0, 16'h0040);
        bus.vw_value = 32'hDEADBEEF; bus.ram_address = 16'h3000; bus.mblock_s3 = 3'd3;
        wait_idle();
        chk("latch_nwrites", 32'(obs_w.size()), 32'd4);
        chk("latch_b0", 32'(obs_w[0]), 32'h2000D4);
        chk("latch_b1", 32'(obs_w[1]), 32'h2001C3);
        chk("latch_b2", 32'(obs_w[2]), 32'h2002B2);
        chk("latch_b3", 32'(obs_w[3]), 32'h2003A1);
        chk("latch_pc", 32'(obs_pc[0]), 32'h0044);

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
